// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame parser
package uart_frame_pkg;
  localparam int LEN_W = 3;

  localparam logic [7:0] SOF_BYTE = 8'h55;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_LEN = 3'd2,
    GET_PAY = 3'd3,
    GET_CHK = 3'd4
  } state_t;
endpackage

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - SOF/CMD/LEN/PAYLOAD/CHK frame parser with ACK/NAK response
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic [LEN_W-1:0]     cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 resp_drop,
  output logic [7:0]           err_cnt
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t               r_state;
  logic                 r_rx_valid_q;
  logic [TO_W-1:0]      r_to_cnt;
  logic [7:0]           r_code;
  logic [7:0]           r_chk;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_idx;
  logic [8*MAX_LEN-1:0] r_pay;
  logic                 r_cmd_valid;
  logic [7:0]           r_cmd_code;
  logic [LEN_W-1:0]     r_cmd_len;
  logic [8*MAX_LEN-1:0] r_cmd_payload;
  logic [7:0]           r_err_cnt;
  logic                 r_resp_pending;
  logic                 r_guard;
  logic                 r_resp_drop;
  logic [7:0]           r_tx_data;

  logic       w_byte_acc;
  logic       w_oversize;
  logic       w_chk_ok;
  logic       w_timeout;
  logic       w_queue;
  logic       w_err;
  logic       w_tx_start;
  logic [7:0] w_resp_byte;

  // uartRX may hold valid for several cycles; only its rising edge carries a byte
  assign w_byte_acc  = rx_valid && !r_rx_valid_q;
  assign w_oversize  = rx_data > 8'(MAX_LEN);
  assign w_chk_ok    = rx_data == r_chk;
  assign w_timeout   = !w_byte_acc && (r_state != IDLE) &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
  assign w_queue     = w_byte_acc &&
                       (((r_state == GET_LEN) && w_oversize) || (r_state == GET_CHK));
  assign w_resp_byte = ((r_state == GET_CHK) && w_chk_ok) ? ACK_BYTE : NAK_BYTE;
  assign w_err       = (w_queue && (w_resp_byte == NAK_BYTE)) || w_timeout;
  // r_guard masks tx_busy for the cycle after a send, before uartTX raises busy
  assign w_tx_start  = r_resp_pending && !tx_busy && !r_guard;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rx_valid_q  <= 1'b0;
      r_to_cnt      <= '0;
      r_code        <= '0;
      r_chk         <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_pay         <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_code    <= '0;
      r_cmd_len     <= '0;
      r_cmd_payload <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_rx_valid_q <= rx_valid;
      r_cmd_valid  <= 1'b0;
      if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_byte_acc) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE: if (rx_data == SOF_BYTE) r_state <= GET_CMD;
          GET_CMD: begin
            r_code  <= rx_data;
            r_chk   <= rx_data;
            r_state <= GET_LEN;
          end
          GET_LEN: begin
            if (w_oversize) begin
              r_state <= IDLE;
            end else begin
              r_len   <= rx_data[LEN_W-1:0];
              r_chk   <= r_chk ^ rx_data;
              r_pay   <= '0;
              r_idx   <= '0;
              r_state <= (rx_data == 8'd0) ? GET_CHK : GET_PAY;
            end
          end
          GET_PAY: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (r_idx == LEN_W'(i)) r_pay[8*i +: 8] <= rx_data;
            end
            r_chk <= r_chk ^ rx_data;
            r_idx <= r_idx + 1'b1;
            if ((r_idx + 1'b1) == r_len) r_state <= GET_CHK;
          end
          GET_CHK: begin
            if (w_chk_ok) begin
              r_cmd_valid   <= 1'b1;
              r_cmd_code    <= r_code;
              r_cmd_len     <= r_len;
              r_cmd_payload <= r_pay;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        if (w_timeout) begin
          r_state  <= IDLE;
          r_to_cnt <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_pending <= 1'b0;
      r_guard        <= 1'b0;
      r_resp_drop    <= 1'b0;
      r_tx_data      <= '0;
    end else begin
      r_guard <= w_tx_start;
      if (w_tx_start) r_resp_pending <= 1'b0;
      // one response slot: a new one arriving while it is occupied is lost
      if (w_queue) begin
        if (r_resp_pending) begin
          r_resp_drop <= 1'b1;
        end else begin
          r_resp_pending <= 1'b1;
          r_tx_data      <= w_resp_byte;
        end
      end
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_start    = w_tx_start;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_code    = r_cmd_code;
  assign cmd_len     = r_cmd_len;
  assign cmd_payload = r_cmd_payload;
  assign resp_drop   = r_resp_drop;
  assign err_cnt     = r_err_cnt;
endmodule
